// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: AHB-Lite slave response multiplexer with a built-in default slave.
// A data-phase select register (dsel) steers HRDATA/HREADY/HRESP from one of four
// slaves, an idle "none" source, or the default slave. The default slave answers
// unmapped active transfers with a two-cycle ERROR response.
// Optional macro AHB_RESP_MUX_ERRCNT_EN adds a saturating default-slave error
// counter (err_count) and capture of the last unmapped address (err_addr).
module ahb_resp_mux #(
  parameter logic [31:0] DEF_RDATA = 32'hDEAD_BEEF,
  parameter int          ERR_CNT_W = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic        HSEL_ROM,
  input  logic        HSEL_SRAM,
  input  logic        HSEL_APB,
  input  logic        HSEL_DMA,
  input  logic [31:0] HRDATA_ROM,
  input  logic [31:0] HRDATA_SRAM,
  input  logic [31:0] HRDATA_APB,
  input  logic [31:0] HRDATA_DMA,
  input  logic        HREADYOUT_ROM,
  input  logic        HREADYOUT_SRAM,
  input  logic        HREADYOUT_APB,
  input  logic        HREADYOUT_DMA,
  input  logic        HRESP_ROM,
  input  logic        HRESP_SRAM,
  input  logic        HRESP_APB,
  input  logic        HRESP_DMA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
`ifdef AHB_RESP_MUX_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          err_addr
`endif
);

  typedef enum logic [2:0] {SEL_NONE, SEL_ROM, SEL_SRAM, SEL_APB, SEL_DMA, SEL_DEF} dsel_t;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_t;

  dsel_t dsel, dec_sel;
  ds_t   ds_state;
  logic  unmapped_act;

  // Address-phase decode: fixed priority among selects, then default slave for
  // active transfers nobody claims.
  always_comb begin
    dec_sel = SEL_NONE;
    if (HSEL_ROM)       dec_sel = SEL_ROM;
    else if (HSEL_SRAM) dec_sel = SEL_SRAM;
    else if (HSEL_APB)  dec_sel = SEL_APB;
    else if (HSEL_DMA)  dec_sel = SEL_DMA;
    else if (HTRANS[1]) dec_sel = SEL_DEF;
  end

  assign unmapped_act = (dec_sel == SEL_DEF);

  // Data-phase select advances only when the bus is ready.
  always_ff @(posedge HCLK) begin
    if (HRESET)      dsel <= SEL_NONE;
    else if (HREADY) dsel <= dec_sel;
  end

  // Default-slave FSM: ERR1 (wait, ERROR) then ERR2 (ready, ERROR).
  always_ff @(posedge HCLK) begin
    if (HRESET) ds_state <= DS_IDLE;
    else begin
      case (ds_state)
        DS_IDLE: if (HREADY && unmapped_act) ds_state <= DS_ERR1;
        DS_ERR1: ds_state <= DS_ERR2;
        DS_ERR2: ds_state <= unmapped_act ? DS_ERR1 : DS_IDLE;
        default: ds_state <= DS_IDLE;
      endcase
    end
  end

  // Response path is purely combinational from dsel so no latency is added.
  always_comb begin
    HRDATA = 32'h0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    case (dsel)
      SEL_ROM:  begin HRDATA = HRDATA_ROM;  HREADY = HREADYOUT_ROM;  HRESP = HRESP_ROM;  end
      SEL_SRAM: begin HRDATA = HRDATA_SRAM; HREADY = HREADYOUT_SRAM; HRESP = HRESP_SRAM; end
      SEL_APB:  begin HRDATA = HRDATA_APB;  HREADY = HREADYOUT_APB;  HRESP = HRESP_APB;  end
      SEL_DMA:  begin HRDATA = HRDATA_DMA;  HREADY = HREADYOUT_DMA;  HRESP = HRESP_DMA;  end
      SEL_DEF:  begin
        HRDATA = DEF_RDATA;
        HREADY = (ds_state != DS_ERR1);
        HRESP  = (ds_state != DS_IDLE);
      end
      default: ;
    endcase
  end

`ifdef AHB_RESP_MUX_ERRCNT_EN
  // Count each new ERROR response (entry into ERR1) and remember its address.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_count <= '0;
      err_addr  <= 32'h0;
    end else if (HREADY && unmapped_act) begin
      if (err_count != {ERR_CNT_W{1'b1}}) err_count <= err_count + 1'b1;
      err_addr <= HADDR;
    end
  end
`else
  // Without error capture the address bus and counter width have no consumer.
  localparam int unused_cnt_w = ERR_CNT_W;
  logic unused_haddr;
  assign unused_haddr = ^{HADDR, unused_cnt_w[0]};
`endif

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Scoreboard bench for ahb_resp_mux: the stimulus process drives one address phase
// per cycle and queues the data-phase response expected in that same cycle; a
// monitor pops and compares on every falling edge.
module tb_ahb_resp_mux;

  localparam logic [31:0] D_ROM  = 32'hA0A0_0001;
  localparam logic [31:0] D_SRAM = 32'h1234_5678;
  localparam logic [31:0] D_APB  = 32'hA9B0_0003;
  localparam logic [31:0] D_DMA  = 32'hD0A0_0004;
  localparam logic [31:0] D_DEF  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] haddr = 32'h0;
  logic [3:0]  sel = 4'h0;   // {rom, sram, apb, dma}
  logic [3:0]  rdy = 4'hF;
  logic [3:0]  rsp = 4'h0;
  logic [31:0] hrdata;
  logic        hready, hresp;
`ifdef AHB_RESP_MUX_ERRCNT_EN
  logic [7:0]  err_count;
  logic [31:0] err_addr;
`endif

  always #5 clk = ~clk;

  ahb_resp_mux dut (
    .HCLK(clk), .HRESET(rst), .HTRANS(htrans), .HADDR(haddr),
    .HSEL_ROM(sel[3]), .HSEL_SRAM(sel[2]), .HSEL_APB(sel[1]), .HSEL_DMA(sel[0]),
    .HRDATA_ROM(D_ROM), .HRDATA_SRAM(D_SRAM), .HRDATA_APB(D_APB), .HRDATA_DMA(D_DMA),
    .HREADYOUT_ROM(rdy[3]), .HREADYOUT_SRAM(rdy[2]), .HREADYOUT_APB(rdy[1]), .HREADYOUT_DMA(rdy[0]),
    .HRESP_ROM(rsp[3]), .HRESP_SRAM(rsp[2]), .HRESP_APB(rsp[1]), .HRESP_DMA(rsp[0]),
    .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp)
`ifdef AHB_RESP_MUX_ERRCNT_EN
    , .err_count(err_count), .err_addr(err_addr)
`endif
  );

  typedef struct {
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;
    logic        ce;
    logic [7:0]  ecnt;
    logic [31:0] eaddr;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  // Pending error-capture expectation attached to the next queued entry.
  logic        ce_next = 1'b0;
  logic [7:0]  ecnt_next = 8'h0;
  logic [31:0] eaddr_next = 32'h0;

  // Monitor: compare whatever response was queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tot++;
        if (hready === e.e_rdy && hresp === e.e_resp && hrdata === e.e_data) n_pass++;
        else $display("FAIL %s: got rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
                      e.name, hready, hresp, hrdata, e.e_rdy, e.e_resp, e.e_data);
`ifdef AHB_RESP_MUX_ERRCNT_EN
        if (e.ce) begin
          n_tot++;
          if (err_count === e.ecnt && err_addr === e.eaddr) n_pass++;
          else $display("FAIL %s_err: got cnt=%0d addr=%h, want cnt=%0d addr=%h",
                        e.name, err_count, err_addr, e.ecnt, e.eaddr);
        end
`endif
      end
    end
  end

  task automatic cyc(input logic r, input logic [1:0] tr, input logic [31:0] ad,
                     input logic [3:0] s, input logic [3:0] rd, input logic [3:0] rs,
                     input logic xr, input logic xp, input logic [31:0] xd, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; htrans = tr; haddr = ad; sel = s; rdy = rd; rsp = rs;
    e.e_rdy = xr; e.e_resp = xp; e.e_data = xd;
    e.ce = ce_next; e.ecnt = ecnt_next; e.eaddr = eaddr_next; e.name = nm;
    ce_next = 1'b0;
    q.push_back(e);
  endtask

  task automatic err_exp(input logic [7:0] c, input logic [31:0] a);
`ifdef AHB_RESP_MUX_ERRCNT_EN
    ce_next = 1'b1; ecnt_next = c; eaddr_next = a;
`else
    ce_next = 1'b0; ecnt_next = c; eaddr_next = a;
`endif
  endtask

  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;

  initial begin
    //   rst tr   addr           sel   rdy   rsp   rdy resp data
    cyc(1, IDL, 32'h0,         4'h0, 4'hF, 4'h0, 1, 0, 32'h0,  "reset0");
    err_exp(0, 0);
    cyc(0, IDL, 32'h0,         4'h0, 4'hF, 4'h0, 1, 0, 32'h0,  "reset1");
    cyc(0, IDL, 32'h0,         4'h0, 4'hF, 4'h0, 1, 0, 32'h0,  "idle_none");
    cyc(0, NSQ, 32'h2000_0000, 4'h4, 4'hF, 4'h0, 1, 0, 32'h0,  "sram_addr");
    cyc(0, IDL, 32'h0,         4'h0, 4'hB, 4'h0, 0, 0, D_SRAM, "sram_wait");
    cyc(0, NSQ, 32'h0000_0100, 4'h9, 4'hF, 4'h0, 1, 0, D_SRAM, "sram_data");
    cyc(0, NSQ, 32'hF000_0000, 4'h0, 4'hF, 4'h0, 1, 0, D_ROM,  "prio_rom_dma");
    err_exp(1, 32'hF000_0000);
    cyc(0, IDL, 32'h0,         4'h0, 4'hF, 4'h0, 0, 1, D_DEF,  "err1_a");
    cyc(0, NSQ, 32'hF000_0004, 4'h0, 4'hF, 4'h0, 1, 1, D_DEF,  "err2_a");
    cyc(0, IDL, 32'h0,         4'h0, 4'hF, 4'h0, 0, 1, D_DEF,  "err1_b");
    cyc(0, IDL, 32'h0,         4'h0, 4'hF, 4'h0, 1, 1, D_DEF,  "err2_b");
    err_exp(2, 32'hF000_0004);
    cyc(0, NSQ, 32'h4000_0000, 4'h2, 4'hF, 4'h0, 1, 0, 32'h0,  "err_done");
    for (int i = 0; i < 5; i++)
      cyc(0, NSQ, 32'h0000_0200, 4'h8, 4'hD, 4'h0, 0, 0, D_APB, "apb_wait");
    cyc(0, NSQ, 32'h0000_0200, 4'h8, 4'hF, 4'h0, 1, 0, D_APB,  "apb_done");
    cyc(0, NSQ, 32'h6000_0000, 4'h1, 4'hF, 4'h0, 1, 0, D_ROM,  "rom_after_apb");
    cyc(0, BSY, 32'h7000_0000, 4'h0, 4'hF, 4'h1, 1, 1, D_DMA,  "dma_error");
    cyc(0, SQ,  32'hF000_0010, 4'h0, 4'hF, 4'h0, 1, 0, 32'h0,  "busy_none");
    err_exp(3, 32'hF000_0010);
    cyc(1, IDL, 32'h0,         4'h0, 4'hF, 4'h0, 0, 1, D_DEF,  "err1_c");
    err_exp(0, 32'h0);
    cyc(0, IDL, 32'h0,         4'h4, 4'hF, 4'h0, 1, 0, 32'h0,  "rst_mid_err");
    cyc(0, NSQ, 32'hF000_00FC, 4'h0, 4'hF, 4'h0, 1, 0, D_SRAM, "sel_on_idle");
    // Continuous unmapped traffic: counter must stick at all-ones.
    for (int k = 0; k < 300; k++) begin
      err_exp((k + 1 > 255) ? 8'd255 : 8'(k + 1), 32'hF000_00FC);
      cyc(0, NSQ, 32'hF000_00FC, 4'h0, 4'hF, 4'h0, 0, 1, D_DEF, "sat_err1");
      if (k == 299) cyc(0, IDL, 32'h0,         4'h0, 4'hF, 4'h0, 1, 1, D_DEF, "sat_err2");
      else          cyc(0, NSQ, 32'hF000_00FC, 4'h0, 4'hF, 4'h0, 1, 1, D_DEF, "sat_err2");
    end
    err_exp(255, 32'hF000_00FC);
    cyc(0, IDL, 32'h0, 4'h0, 4'hF, 4'h0, 1, 0, 32'h0, "sat_idle");
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tot++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
